// File: rtl/alu_sched.sv
// alu_sched: round-robin arbiter for two requesters sharing a 4-bit ALU.
// 8-bit adds are split into low, high and carry-fix passes.
module alu_sched #(
  parameter logic RR_INIT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [2:0] req0_op,
  input  logic       req0_wide,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [2:0] req1_op,
  input  logic       req1_wide,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [3:0] alu_result,
  input  logic       alu_carry,
  input  logic       alu_overflow,
  input  logic       alu_zero,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_result,
  output logic       rsp_carry,
  output logic       rsp_overflow,
  output logic       rsp_zero
);

  typedef enum logic [2:0] {
    IDLE, EXEC, LO, HI, FIX, RESP
  } state_t;

  state_t     state;
  logic       last;
  logic       sel;
  logic       gnt;
  logic [2:0] g_op;
  logic       g_wide;
  logic [7:0] g_a;
  logic [7:0] g_b;
  logic [3:0] a_hi;
  logic [3:0] b_hi;
  logic [3:0] sum_lo;
  logic       c_lo;
  logic       c_hi;
  logic [7:0] fix_res;

  assign fix_res = {alu_result, sum_lo};

  // Pick a requester (sole valid wins, ties go to the one not granted last)
  always_comb begin
    sel = (req0_valid & req1_valid) ? ~last : req1_valid;
    gnt = (state == IDLE) & ~rst & (req0_valid | req1_valid);
    req0_ready = gnt & ~sel;
    req1_ready = gnt & sel;
    g_op = sel ? req1_op : req0_op;
    g_a  = sel ? req1_a : req0_a;
    g_b  = sel ? req1_b : req0_b;
    g_wide = (sel ? req1_wide : req0_wide) & (g_op == 3'b000);
  end

  // Sequencer: grant, ALU passes, response hold
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last         <= RR_INIT;
      alu_a        <= 4'h0;
      alu_b        <= 4'h0;
      alu_op       <= 3'b000;
      a_hi         <= 4'h0;
      b_hi         <= 4'h0;
      sum_lo       <= 4'h0;
      c_lo         <= 1'b0;
      c_hi         <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= 8'h00;
      rsp_carry    <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_zero     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt) begin
            last   <= sel;
            rsp_id <= sel;
            a_hi   <= g_a[7:4];
            b_hi   <= g_b[7:4];
            alu_a  <= g_a[3:0];
            alu_b  <= g_b[3:0];
            alu_op <= g_wide ? 3'b000 : g_op;
            state  <= g_wide ? LO : EXEC;
          end
        end
        EXEC: begin
          rsp_result   <= {4'h0, alu_result};
          rsp_carry    <= alu_carry;
          rsp_overflow <= alu_overflow;
          rsp_zero     <= alu_zero;
          rsp_valid    <= 1'b1;
          alu_a        <= 4'h0;
          alu_b        <= 4'h0;
          alu_op       <= 3'b000;
          state        <= RESP;
        end
        LO: begin
          sum_lo <= alu_result;
          c_lo   <= alu_carry;
          alu_a  <= a_hi;
          alu_b  <= b_hi;
          state  <= HI;
        end
        HI: begin
          c_hi  <= alu_carry;
          alu_a <= alu_result;
          alu_b <= {3'b000, c_lo};
          state <= FIX;
        end
        FIX: begin
          rsp_result   <= fix_res;
          rsp_carry    <= c_hi | alu_carry;
          rsp_zero     <= (fix_res == 8'h00);
          rsp_overflow <= (a_hi[3] == b_hi[3]) &
                          (fix_res[7] != a_hi[3]);
          rsp_valid    <= 1'b1;
          alu_a        <= 4'h0;
          alu_b        <= 4'h0;
          state        <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: directed and randomized checks of alu_sched
// against a transaction-level reference model.
module tb_alu_sched;

  logic       clk;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [2:0] req0_op, req1_op;
  logic       req0_wide, req1_wide;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_op;
  logic       alu_carry, alu_overflow, alu_zero;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [7:0] rsp_result;
  logic       rsp_carry, rsp_overflow, rsp_zero;

  int nvec = 0;
  int nerr = 0;

  alu_sched #(.RR_INIT(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_op(req0_op), .req0_wide(req0_wide),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_op(req1_op), .req1_wide(req1_wide),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .alu_overflow(alu_overflow), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_overflow(rsp_overflow),
    .rsp_zero(rsp_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared 4-bit ALU; returns {carry, overflow, zero, result}
  function automatic logic [6:0] alu4(input logic [2:0] op,
                                      input logic [3:0] a,
                                      input logic [3:0] b);
    logic [4:0] s;
    logic [3:0] r;
    logic       c, v;
    s = 5'd0; r = 4'd0; c = 1'b0; v = 1'b0;
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4];
        v = (a[3] == b[3]) && (r[3] != a[3]);
      end
      3'd1: begin
        s = {1'b0, a} - {1'b0, b}; r = s[3:0]; c = s[4];
        v = (a[3] != b[3]) && (r[3] != a[3]);
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~a;
      3'd6: begin r = {a[2:0], 1'b0}; c = a[3]; end
      default: begin r = {1'b0, a[3:1]}; c = a[0]; end
    endcase
    return {c, v, (r == 4'd0), r};
  endfunction

  always_comb begin
    {alu_carry, alu_overflow, alu_zero, alu_result} =
      alu4(alu_op, alu_a, alu_b);
  end

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model state
  bit          m_idle = 1'b1;
  bit          m_resp = 1'b0;
  bit          m_last = 1'b1;
  logic [10:0] aq[$];
  logic        e_id;
  logic [7:0]  e_res;
  logic        e_c, e_v, e_z;
  logic        acc0 = 1'b0;
  logic        acc1 = 1'b0;

  // Per-cycle compare against the model, then advance the model
  always @(negedge clk) begin
    logic       g, er0, er1, w;
    logic [2:0] op;
    logic [7:0] a, b;
    logic [8:0] s;
    logic [4:0] lo, hi;
    logic [6:0] r;
    g = 1'b0; er0 = 1'b0; er1 = 1'b0;
    if (!rst && m_idle && (req0_valid || req1_valid)) begin
      g = (req0_valid && req1_valid) ? !m_last : req1_valid;
      er0 = !g;
      er1 = g;
    end
    chk("ready0", 16'(req0_ready), 16'(er0));
    chk("ready1", 16'(req1_ready), 16'(er1));
    chk("rsp_valid", 16'(rsp_valid), 16'(m_resp));
    if (m_resp) begin
      chk("rsp_id", 16'(rsp_id), 16'(e_id));
      chk("rsp_result", 16'(rsp_result), 16'(e_res));
      chk("rsp_flags", 16'({rsp_carry, rsp_overflow, rsp_zero}),
          16'({e_c, e_v, e_z}));
    end
    if (m_idle || m_resp)
      chk("alu_idle", 16'({alu_op, alu_a, alu_b}), 16'd0);
    else if (aq.size() > 0)
      chk("alu_pass", 16'({alu_op, alu_a, alu_b}), 16'(aq[0]));
    acc0 = req0_valid && req0_ready;
    acc1 = req1_valid && req1_ready;
    if (rst) begin
      m_idle = 1'b1; m_resp = 1'b0; m_last = 1'b1;
      aq.delete();
    end else if (m_idle) begin
      if (req0_valid || req1_valid) begin
        m_last = g;
        e_id = g;
        op = g ? req1_op : req0_op;
        w  = g ? req1_wide : req0_wide;
        a  = g ? req1_a : req0_a;
        b  = g ? req1_b : req0_b;
        if (w && op == 3'd0) begin
          s = {1'b0, a} + {1'b0, b};
          e_res = s[7:0];
          e_c = s[8];
          e_z = (s[7:0] == 8'd0);
          e_v = (a[7] == b[7]) && (s[7] != a[7]);
          lo = {1'b0, a[3:0]} + {1'b0, b[3:0]};
          hi = {1'b0, a[7:4]} + {1'b0, b[7:4]};
          aq.push_back({3'd0, a[3:0], b[3:0]});
          aq.push_back({3'd0, a[7:4], b[7:4]});
          aq.push_back({3'd0, hi[3:0], 3'b000, lo[4]});
        end else begin
          r = alu4(op, a[3:0], b[3:0]);
          e_res = {4'h0, r[3:0]};
          {e_c, e_v, e_z} = r[6:4];
          aq.push_back({op, a[3:0], b[3:0]});
        end
        m_idle = 1'b0;
      end
    end else if (m_resp) begin
      if (rsp_ready) begin
        m_resp = 1'b0;
        m_idle = 1'b1;
      end
    end else begin
      void'(aq.pop_front());
      if (aq.size() == 0) m_resp = 1'b1;
    end
  end

  task automatic gen(output logic v, output logic [2:0] op,
                     output logic w, output logic [7:0] a,
                     output logic [7:0] b);
    v  = 1'($urandom_range(0, 1));
    op = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
    w  = 1'($urandom_range(0, 1));
    a  = 8'($urandom_range(0, 255));
    b  = 8'($urandom_range(0, 255));
  endtask

  initial begin
    logic ids[$];
    logic [7:0] hold;
    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 0; req0_op = 0; req0_wide = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = 0; req1_wide = 0; req1_a = 0; req1_b = 0;
    repeat (2) step();
    chk("rst_valid", 16'(rsp_valid), 16'd0);
    chk("rst_result", 16'(rsp_result), 16'd0);
    chk("rst_id", 16'(rsp_id), 16'd0);
    chk("rst_flags", 16'({rsp_carry, rsp_overflow, rsp_zero}), 16'd0);
    req0_valid = 1'b1;
    #1 chk("rst_ready0", 16'(req0_ready), 16'd0);
    req0_valid = 1'b0;
    rst = 1'b0;
    step();

    // narrow add 07+01 from req0
    req0_valid = 1; req0_op = 0; req0_wide = 0;
    req0_a = 8'h07; req0_b = 8'h01;
    #1 chk("n_grant", 16'(req0_ready), 16'd1);
    step(); req0_valid = 0;
    step();
    chk("n_valid", 16'(rsp_valid), 16'd1);
    chk("n_id", 16'(rsp_id), 16'd0);
    chk("n_result", 16'(rsp_result), 16'h08);
    chk("n_flags", 16'({rsp_carry, rsp_overflow, rsp_zero}), 16'b010);
    rsp_ready = 1;
    step();

    // wide add 0F+01 from req1
    req1_valid = 1; req1_op = 0; req1_wide = 1;
    req1_a = 8'h0F; req1_b = 8'h01;
    step(); req1_valid = 0;
    chk("w_lo", 16'({alu_a, alu_b}), 16'hF1);
    step();
    chk("w_hi", 16'({alu_a, alu_b}), 16'h00);
    step();
    chk("w_fix", 16'({alu_a, alu_b}), 16'h01);
    step();
    chk("w_result", 16'(rsp_result), 16'h10);
    chk("w_flags", 16'({rsp_carry, rsp_overflow, rsp_zero}), 16'b000);
    chk("w_id", 16'(rsp_id), 16'd1);
    step();

    // wide add FF+01 from req0
    req0_valid = 1; req0_op = 0; req0_wide = 1;
    req0_a = 8'hFF; req0_b = 8'h01;
    step(); req0_valid = 0;
    repeat (3) step();
    chk("w2_result", 16'(rsp_result), 16'h00);
    chk("w2_flags", 16'({rsp_carry, rsp_overflow, rsp_zero}), 16'b101);
    step();

    // ties from reset alternate 0,1,0
    rst = 1; step(); rst = 0;
    req0_valid = 1; req0_wide = 0; req0_op = 0; req0_a = 1; req0_b = 2;
    req1_valid = 1; req1_wide = 0; req1_op = 0; req1_a = 3; req1_b = 4;
    for (int i = 0; i < 12; i++) begin
      if (rsp_valid && rsp_ready) ids.push_back(rsp_id);
      step();
    end
    req0_valid = 0; req1_valid = 0;
    chk("tie_count", 16'(ids.size() >= 3), 16'd1);
    if (ids.size() >= 3)
      chk("tie_seq", 16'({ids[0], ids[1], ids[2]}), 16'b010);
    repeat (6) step();

    // response backpressure with req1 pending
    rsp_ready = 0;
    req0_valid = 1; req0_op = 3'd2; req0_wide = 0;
    req0_a = 8'h0C; req0_b = 8'h0A;
    step(); req0_valid = 0;
    req1_valid = 1; req1_op = 3'd4; req1_wide = 0;
    req1_a = 8'h05; req1_b = 8'h03;
    step();
    hold = rsp_result;
    chk("bp_result", 16'(hold), 16'h08);
    for (int i = 0; i < 3; i++) begin
      chk("bp_ready1", 16'(req1_ready), 16'd0);
      chk("bp_hold", 16'({rsp_valid, rsp_result}), 16'({1'b1, hold}));
      step();
    end
    rsp_ready = 1;
    step();
    chk("bp_grant1", 16'(req1_ready), 16'd1);
    step(); req1_valid = 0;
    repeat (3) step();

    // reset during HI of a wide add
    req0_valid = 1; req0_op = 0; req0_wide = 1;
    req0_a = 8'h12; req0_b = 8'h34;
    step(); req0_valid = 0;
    step(); rst = 1;
    step(); rst = 0;
    for (int i = 0; i < 6; i++) begin
      chk("drop_valid", 16'(rsp_valid), 16'd0);
      step();
    end

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (!req0_valid || acc0)
        gen(req0_valid, req0_op, req0_wide, req0_a, req0_b);
      if (!req1_valid || acc1)
        gen(req1_valid, req1_op, req1_wide, req1_a, req1_b);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
